// File: rtl/gprf_wb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gprf_wb_ctrl                                                             |
// | Write-back arbiter, pending-register scoreboard and read/write select    |
// | sequencer for the r0-r7 / rmod general-purpose register file.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gprf_wb_ctrl #(
  parameter int DAT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  // ALU write port
  input  logic             alu_wr_vld,
  input  logic [2:0]       alu_wr_idx,
  input  logic             alu_wr_rmod,
  input  logic [DAT_W-1:0] alu_wr_dat,
  output logic             alu_wr_rdy,
  // GFU write port
  input  logic             gfu_wr_vld,
  input  logic [2:0]       gfu_wr_idx,
  input  logic [DAT_W-1:0] gfu_wr_dat,
  output logic             gfu_wr_rdy,
  // Issue port
  input  logic             iss_vld,
  input  logic [2:0]       iss_src1,
  input  logic [2:0]       iss_src2,
  input  logic             iss_src1_en,
  input  logic             iss_src2_en,
  input  logic [2:0]       iss_dst,
  input  logic             iss_dst_en,
  input  logic             iss_rmod_rd,
  output logic             iss_rdy,
  // Register file control
  output logic [7:0]       bus1_t_sel,
  output logic             bus1_rmod_t_sel,
  output logic [DAT_W-1:0] bus1_dat,
  output logic [7:0]       bus1_r_sel,
  output logic [7:0]       bus2_r_sel,
  output logic             bus1_rmod_r_sel,
  output logic [7:0]       pend
);

  localparam logic c_ALU = 1'b0;
  localparam logic c_GFU = 1'b1;

  logic             r_last;
  logic [7:0]       r_t_sel;
  logic             r_rmod_t_sel;
  logic [DAT_W-1:0] r_dat;
  logic [7:0]       r_r1_sel;
  logic [7:0]       r_r2_sel;
  logic             r_rmod_r_sel;
  logic [7:0]       r_pend;

  logic             w_alu_gnt;
  logic             w_gfu_gnt;
  logic [7:0]       w_t_sel_nxt;
  logic             w_rmod_t_sel_nxt;
  logic [DAT_W-1:0] w_dat_nxt;
  logic             w_wr_busy;
  logic             w_hazard;
  logic             w_iss_acc;
  logic [7:0]       w_pend_set;
  logic [7:0]       w_pend_nxt;
  logic [7:0]       w_r1_sel_nxt;
  logic [7:0]       w_r2_sel_nxt;

  // Round-robin grant: under contention the requester not granted last wins.
  always_comb begin
    w_alu_gnt = 1'b0;
    w_gfu_gnt = 1'b0;
    if (!rst) begin
      if (alu_wr_vld && gfu_wr_vld) begin
        w_alu_gnt = (r_last == c_GFU);
        w_gfu_gnt = (r_last == c_ALU);
      end else begin
        w_alu_gnt = alu_wr_vld;
        w_gfu_gnt = gfu_wr_vld;
      end
    end
  end

  always_comb begin
    w_t_sel_nxt      = 8'h00;
    w_rmod_t_sel_nxt = 1'b0;
    w_dat_nxt        = r_dat;
    if (w_alu_gnt) begin
      w_dat_nxt = alu_wr_dat;
      if (alu_wr_rmod) begin
        w_rmod_t_sel_nxt = 1'b1;
      end else begin
        w_t_sel_nxt[alu_wr_idx] = 1'b1;
      end
    end else if (w_gfu_gnt) begin
      w_dat_nxt               = gfu_wr_dat;
      w_t_sel_nxt[gfu_wr_idx] = 1'b1;
    end
  end

  // Issue is held off while a write occupies the write stage so read selects
  // never coincide with a register update edge.
  always_comb begin
    w_wr_busy = (|r_t_sel) | r_rmod_t_sel;
    w_hazard  = (iss_src1_en & r_pend[iss_src1]) |
                (iss_src2_en & r_pend[iss_src2]) |
                (iss_dst_en  & r_pend[iss_dst]);
    w_iss_acc = ~rst & iss_vld & ~w_wr_busy & ~w_hazard;
  end

  always_comb begin
    w_pend_set   = 8'h00;
    w_r1_sel_nxt = 8'h00;
    w_r2_sel_nxt = 8'h00;
    if (w_iss_acc) begin
      if (iss_dst_en)  w_pend_set   = 8'h01 << iss_dst;
      if (iss_src1_en) w_r1_sel_nxt = 8'h01 << iss_src1;
      if (iss_src2_en) w_r2_sel_nxt = 8'h01 << iss_src2;
    end
    // A new reservation overrides a completing write to the same register.
    w_pend_nxt = (r_pend & ~r_t_sel) | w_pend_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last       <= c_GFU;
      r_t_sel      <= 8'h00;
      r_rmod_t_sel <= 1'b0;
      r_dat        <= '0;
      r_r1_sel     <= 8'h00;
      r_r2_sel     <= 8'h00;
      r_rmod_r_sel <= 1'b0;
      r_pend       <= 8'h00;
    end else begin
      if (w_alu_gnt) begin
        r_last <= c_ALU;
      end else if (w_gfu_gnt) begin
        r_last <= c_GFU;
      end
      r_t_sel      <= w_t_sel_nxt;
      r_rmod_t_sel <= w_rmod_t_sel_nxt;
      r_dat        <= w_dat_nxt;
      r_r1_sel     <= w_r1_sel_nxt;
      r_r2_sel     <= w_r2_sel_nxt;
      r_rmod_r_sel <= w_iss_acc & iss_rmod_rd;
      r_pend       <= w_pend_nxt;
    end
  end

  assign alu_wr_rdy      = w_alu_gnt;
  assign gfu_wr_rdy      = w_gfu_gnt;
  assign iss_rdy         = w_iss_acc;
  assign bus1_t_sel      = r_t_sel;
  assign bus1_rmod_t_sel = r_rmod_t_sel;
  assign bus1_dat        = r_dat;
  assign bus1_r_sel      = r_r1_sel;
  assign bus2_r_sel      = r_r2_sel;
  assign bus1_rmod_r_sel = r_rmod_r_sel;
  assign pend            = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_gprf_wb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gprf_wb_ctrl                                                          |
// | Directed self-checking bench for gprf_wb_ctrl.                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_gprf_wb_ctrl;

  localparam int DAT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             alu_wr_vld, alu_wr_rmod, alu_wr_rdy;
  logic [2:0]       alu_wr_idx;
  logic [DAT_W-1:0] alu_wr_dat;
  logic             gfu_wr_vld, gfu_wr_rdy;
  logic [2:0]       gfu_wr_idx;
  logic [DAT_W-1:0] gfu_wr_dat;
  logic             iss_vld, iss_src1_en, iss_src2_en, iss_dst_en, iss_rmod_rd, iss_rdy;
  logic [2:0]       iss_src1, iss_src2, iss_dst;
  logic [7:0]       bus1_t_sel, bus1_r_sel, bus2_r_sel, pend;
  logic             bus1_rmod_t_sel, bus1_rmod_r_sel;
  logic [DAT_W-1:0] bus1_dat;

  int checks = 0;
  int errors = 0;

  gprf_wb_ctrl #(.DAT_W(DAT_W)) dut (
    .clk(clk), .rst(rst),
    .alu_wr_vld(alu_wr_vld), .alu_wr_idx(alu_wr_idx), .alu_wr_rmod(alu_wr_rmod),
    .alu_wr_dat(alu_wr_dat), .alu_wr_rdy(alu_wr_rdy),
    .gfu_wr_vld(gfu_wr_vld), .gfu_wr_idx(gfu_wr_idx), .gfu_wr_dat(gfu_wr_dat),
    .gfu_wr_rdy(gfu_wr_rdy),
    .iss_vld(iss_vld), .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_src1_en(iss_src1_en), .iss_src2_en(iss_src2_en), .iss_dst(iss_dst),
    .iss_dst_en(iss_dst_en), .iss_rmod_rd(iss_rmod_rd), .iss_rdy(iss_rdy),
    .bus1_t_sel(bus1_t_sel), .bus1_rmod_t_sel(bus1_rmod_t_sel), .bus1_dat(bus1_dat),
    .bus1_r_sel(bus1_r_sel), .bus2_r_sel(bus2_r_sel), .bus1_rmod_r_sel(bus1_rmod_r_sel),
    .pend(pend)
  );

  always #5 clk = ~clk;

  task automatic idle();
    alu_wr_vld = 0; alu_wr_idx = 0; alu_wr_rmod = 0; alu_wr_dat = 0;
    gfu_wr_vld = 0; gfu_wr_idx = 0; gfu_wr_dat = 0;
    iss_vld = 0; iss_src1 = 0; iss_src2 = 0; iss_src1_en = 0; iss_src2_en = 0;
    iss_dst = 0; iss_dst_en = 0; iss_rmod_rd = 0;
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    alu_wr_vld = 1; gfu_wr_vld = 1; iss_vld = 1;
    #1;
    checks++; if (alu_wr_rdy !== 1'b0) begin errors++; $display("FAIL rst_alu_rdy actual=%b expected=0", alu_wr_rdy); end
    checks++; if (gfu_wr_rdy !== 1'b0) begin errors++; $display("FAIL rst_gfu_rdy actual=%b expected=0", gfu_wr_rdy); end
    checks++; if (iss_rdy !== 1'b0) begin errors++; $display("FAIL rst_iss_rdy actual=%b expected=0", iss_rdy); end
    tick();
    tick();
    checks++; if (bus1_t_sel !== 8'h00) begin errors++; $display("FAIL rst_t_sel actual=%h expected=00", bus1_t_sel); end
    checks++; if (bus1_rmod_t_sel !== 1'b0) begin errors++; $display("FAIL rst_rmod_t actual=%b expected=0", bus1_rmod_t_sel); end
    checks++; if (bus1_dat !== 16'h0000) begin errors++; $display("FAIL rst_dat actual=%h expected=0000", bus1_dat); end
    checks++; if ({bus1_r_sel, bus2_r_sel, bus1_rmod_r_sel} !== 17'h0) begin errors++; $display("FAIL rst_r_sel actual=%h/%h/%b expected=00/00/0", bus1_r_sel, bus2_r_sel, bus1_rmod_r_sel); end
    checks++; if (pend !== 8'h00) begin errors++; $display("FAIL rst_pend actual=%h expected=00", pend); end
    idle();
    rst = 0;
  endtask

  task automatic test_alu_write();
    alu_wr_vld = 1; alu_wr_idx = 3; alu_wr_dat = 16'h1234;
    #1;
    checks++; if (alu_wr_rdy !== 1'b1) begin errors++; $display("FAIL alu_rdy actual=%b expected=1", alu_wr_rdy); end
    tick();
    idle();
    iss_vld = 1;
    #1;
    checks++; if (bus1_t_sel !== 8'h08) begin errors++; $display("FAIL alu_t_sel actual=%h expected=08", bus1_t_sel); end
    checks++; if (bus1_rmod_t_sel !== 1'b0) begin errors++; $display("FAIL alu_rmod_t actual=%b expected=0", bus1_rmod_t_sel); end
    checks++; if (bus1_dat !== 16'h1234) begin errors++; $display("FAIL alu_dat actual=%h expected=1234", bus1_dat); end
    checks++; if (iss_rdy !== 1'b0) begin errors++; $display("FAIL wr_busy_iss_rdy actual=%b expected=0", iss_rdy); end
    iss_vld = 0;
    tick();
    checks++; if (bus1_t_sel !== 8'h00) begin errors++; $display("FAIL alu_idle_t_sel actual=%h expected=00", bus1_t_sel); end
    checks++; if (bus1_dat !== 16'h1234) begin errors++; $display("FAIL alu_dat_hold actual=%h expected=1234", bus1_dat); end
  endtask

  task automatic test_arbitration();
    logic       exp_alu;
    logic [7:0] exp_sel;
    do_reset();
    alu_wr_vld = 1; alu_wr_idx = 1; alu_wr_dat = 16'hAAAA;
    gfu_wr_vld = 1; gfu_wr_idx = 2; gfu_wr_dat = 16'hBBBB;
    for (int i = 0; i < 4; i++) begin
      exp_alu = ((i % 2) == 0);
      exp_sel = exp_alu ? 8'h02 : 8'h04;
      #1;
      checks++; if ({alu_wr_rdy, gfu_wr_rdy} !== {exp_alu, ~exp_alu}) begin errors++; $display("FAIL arb_rdy[%0d] actual=%b%b expected=%b%b", i, alu_wr_rdy, gfu_wr_rdy, exp_alu, ~exp_alu); end
      tick();
      checks++; if (bus1_t_sel !== exp_sel) begin errors++; $display("FAIL arb_t_sel[%0d] actual=%h expected=%h", i, bus1_t_sel, exp_sel); end
    end
    idle();
    tick();
  endtask

  task automatic test_raw();
    iss_vld = 1; iss_dst = 5; iss_dst_en = 1;
    #1;
    checks++; if (iss_rdy !== 1'b1) begin errors++; $display("FAIL raw_rsv_rdy actual=%b expected=1", iss_rdy); end
    tick();
    checks++; if (pend !== 8'h20) begin errors++; $display("FAIL raw_pend_set actual=%h expected=20", pend); end
    iss_dst_en = 0; iss_dst = 0; iss_src1 = 5; iss_src1_en = 1;
    #1;
    checks++; if (iss_rdy !== 1'b0) begin errors++; $display("FAIL raw_stall0 actual=%b expected=0", iss_rdy); end
    tick();
    checks++; if (iss_rdy !== 1'b0) begin errors++; $display("FAIL raw_stall1 actual=%b expected=0", iss_rdy); end
    gfu_wr_vld = 1; gfu_wr_idx = 5; gfu_wr_dat = 16'h5555;
    #1;
    checks++; if (gfu_wr_rdy !== 1'b1) begin errors++; $display("FAIL raw_gfu_rdy actual=%b expected=1", gfu_wr_rdy); end
    tick();
    gfu_wr_vld = 0;
    #1;
    checks++; if (bus1_t_sel !== 8'h20) begin errors++; $display("FAIL raw_t_sel actual=%h expected=20", bus1_t_sel); end
    checks++; if (iss_rdy !== 1'b0) begin errors++; $display("FAIL raw_stall2 actual=%b expected=0", iss_rdy); end
    tick();
    checks++; if (pend !== 8'h00) begin errors++; $display("FAIL raw_pend_clr actual=%h expected=00", pend); end
    checks++; if (iss_rdy !== 1'b1) begin errors++; $display("FAIL raw_accept actual=%b expected=1", iss_rdy); end
    tick();
    idle();
    #1;
    checks++; if (bus1_r_sel !== 8'h20) begin errors++; $display("FAIL raw_r1_sel actual=%h expected=20", bus1_r_sel); end
    checks++; if (bus2_r_sel !== 8'h00) begin errors++; $display("FAIL raw_r2_sel actual=%h expected=00", bus2_r_sel); end
    tick();
    checks++; if (bus1_r_sel !== 8'h00) begin errors++; $display("FAIL raw_r1_drop actual=%h expected=00", bus1_r_sel); end
  endtask

  task automatic test_waw();
    iss_vld = 1; iss_dst = 2; iss_dst_en = 1;
    #1;
    checks++; if (iss_rdy !== 1'b1) begin errors++; $display("FAIL waw_rsv_rdy actual=%b expected=1", iss_rdy); end
    tick();
    checks++; if (pend !== 8'h04) begin errors++; $display("FAIL waw_pend actual=%h expected=04", pend); end
    iss_src1 = 3; iss_src2 = 3; iss_src1_en = 1; iss_src2_en = 1;
    #1;
    checks++; if (iss_rdy !== 1'b0) begin errors++; $display("FAIL waw_stall0 actual=%b expected=0", iss_rdy); end
    alu_wr_vld = 1; alu_wr_idx = 2; alu_wr_dat = 16'hBEEF;
    #1;
    checks++; if (alu_wr_rdy !== 1'b1) begin errors++; $display("FAIL waw_alu_rdy actual=%b expected=1", alu_wr_rdy); end
    tick();
    alu_wr_vld = 0;
    #1;
    checks++; if (bus1_t_sel !== 8'h04) begin errors++; $display("FAIL waw_t_sel actual=%h expected=04", bus1_t_sel); end
    checks++; if (bus1_dat !== 16'hBEEF) begin errors++; $display("FAIL waw_dat actual=%h expected=beef", bus1_dat); end
    checks++; if (iss_rdy !== 1'b0) begin errors++; $display("FAIL waw_stall1 actual=%b expected=0", iss_rdy); end
    tick();
    checks++; if (iss_rdy !== 1'b1) begin errors++; $display("FAIL waw_accept actual=%b expected=1", iss_rdy); end
    tick();
    idle();
    #1;
    checks++; if (pend !== 8'h04) begin errors++; $display("FAIL waw_pend_reset actual=%h expected=04", pend); end
    checks++; if ({bus1_r_sel, bus2_r_sel} !== 16'h0808) begin errors++; $display("FAIL waw_same_src actual=%h/%h expected=08/08", bus1_r_sel, bus2_r_sel); end
    tick();
  endtask

  task automatic test_rmod();
    alu_wr_vld = 1; alu_wr_rmod = 1; alu_wr_idx = 6; alu_wr_dat = 16'h00FF;
    #1;
    checks++; if (alu_wr_rdy !== 1'b1) begin errors++; $display("FAIL rmod_alu_rdy actual=%b expected=1", alu_wr_rdy); end
    tick();
    idle();
    #1;
    checks++; if (bus1_rmod_t_sel !== 1'b1) begin errors++; $display("FAIL rmod_t_sel actual=%b expected=1", bus1_rmod_t_sel); end
    checks++; if (bus1_t_sel !== 8'h00) begin errors++; $display("FAIL rmod_gpr_t_sel actual=%h expected=00", bus1_t_sel); end
    checks++; if (bus1_dat !== 16'h00FF) begin errors++; $display("FAIL rmod_dat actual=%h expected=00ff", bus1_dat); end
    checks++; if (pend !== 8'h04) begin errors++; $display("FAIL rmod_pend actual=%h expected=04", pend); end
    tick();
    checks++; if (bus1_rmod_t_sel !== 1'b0) begin errors++; $display("FAIL rmod_t_drop actual=%b expected=0", bus1_rmod_t_sel); end
    iss_vld = 1; iss_rmod_rd = 1;
    #1;
    checks++; if (iss_rdy !== 1'b1) begin errors++; $display("FAIL rmod_iss_rdy actual=%b expected=1", iss_rdy); end
    tick();
    idle();
    #1;
    checks++; if (bus1_rmod_r_sel !== 1'b1) begin errors++; $display("FAIL rmod_r_sel actual=%b expected=1", bus1_rmod_r_sel); end
    checks++; if (bus1_r_sel !== 8'h00) begin errors++; $display("FAIL rmod_r1_sel actual=%h expected=00", bus1_r_sel); end
    tick();
    checks++; if (bus1_rmod_r_sel !== 1'b0) begin errors++; $display("FAIL rmod_r_drop actual=%b expected=0", bus1_rmod_r_sel); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      iss_vld = 1; iss_dst_en = 1; iss_dst = 3'(i);
      tick();
    end
    idle();
    #1;
    checks++; if (pend !== 8'hFF) begin errors++; $display("FAIL mid_pend_full actual=%h expected=ff", pend); end
    alu_wr_vld = 1; alu_wr_idx = 0; alu_wr_dat = 16'h1111;
    tick();
    alu_wr_vld = 0;
    #1;
    checks++; if (bus1_t_sel !== 8'h01) begin errors++; $display("FAIL mid_t_sel actual=%h expected=01", bus1_t_sel); end
    rst = 1; alu_wr_vld = 1; iss_vld = 1;
    #1;
    checks++; if ({alu_wr_rdy, iss_rdy} !== 2'b00) begin errors++; $display("FAIL mid_rst_rdy actual=%b%b expected=00", alu_wr_rdy, iss_rdy); end
    tick();
    checks++; if ({bus1_t_sel, bus1_rmod_t_sel, bus1_r_sel, bus2_r_sel, bus1_rmod_r_sel} !== 26'h0) begin errors++; $display("FAIL mid_sel_clear actual=%h/%b/%h/%h/%b expected=0", bus1_t_sel, bus1_rmod_t_sel, bus1_r_sel, bus2_r_sel, bus1_rmod_r_sel); end
    checks++; if (bus1_dat !== 16'h0000) begin errors++; $display("FAIL mid_dat actual=%h expected=0000", bus1_dat); end
    checks++; if (pend !== 8'h00) begin errors++; $display("FAIL mid_pend actual=%h expected=00", pend); end
    idle();
    rst = 0;
    tick();
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_alu_write();
    test_arbitration();
    test_raw();
    test_waw();
    test_rmod();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
